// File: rtl/config_chain_loader.sv
// config_chain_loader
//   Serial bitstream transmitter for the daisy-chained tile configuration
//   shift registers. It accepts WORD_WIDTH-bit words over a valid/ready
//   stream and shifts exactly CHAIN_LENGTH bits, MSB-first, into the head
//   of the chain. config_enable is high only while a valid bit is presented.
// Ports
//   config_clock     configuration clock (shared with the tile chain)
//   config_nreset    asynchronous active-low reset
//   start            1-cycle load request, honoured only in IDLE
//   abort            synchronous cancel, wins over start
//   word_data        bitstream word, MSB shifted first
//   word_valid       word_data valid
//   word_ready       loader accepts word_data this cycle (combinational)
//   config_data_out  serial bit to the first tile's config_in (registered)
//   config_enable    chain shift enable to every tile (registered)
//   busy             high while loading
//   done             level; last load completed all CHAIN_LENGTH bits
module config_chain_loader #(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned CHAIN_LENGTH = 96
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_data_out,
  output logic                  config_enable,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NUM_WORDS = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned BIW       = $clog2(CHAIN_LENGTH + 1);
  localparam int unsigned WAW       = $clog2(NUM_WORDS + 1);
  localparam int unsigned WBW       = $clog2(WORD_WIDTH + 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                state, state_nxt;
  logic [BIW-1:0]        bits_issued, bits_issued_nxt, bits_left;
  logic [WAW-1:0]        words_accepted, words_accepted_nxt;
  logic [WBW-1:0]        word_bits_left, word_bits_left_nxt;
  logic [WORD_WIDTH-1:0] shreg, shreg_nxt;
  logic                  data_nxt, enable_nxt, done_nxt;
  logic                  accept;

  assign bits_left  = BIW'(CHAIN_LENGTH) - bits_issued;
  assign word_ready = (state == LOAD) && (word_bits_left == '0) &&
                      (words_accepted < WAW'(NUM_WORDS));
  assign accept     = word_valid && word_ready;
  assign busy       = (state == LOAD);

  always_comb begin
    state_nxt          = state;
    bits_issued_nxt    = bits_issued;
    words_accepted_nxt = words_accepted;
    word_bits_left_nxt = word_bits_left;
    shreg_nxt          = shreg;
    data_nxt           = config_data_out;
    enable_nxt         = 1'b0;
    done_nxt           = done;
    if (abort) begin
      state_nxt          = IDLE;
      done_nxt           = 1'b0;
      word_bits_left_nxt = '0;
      shreg_nxt          = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt          = LOAD;
            done_nxt           = 1'b0;
            bits_issued_nxt    = '0;
            words_accepted_nxt = '0;
            word_bits_left_nxt = '0;
          end
        end
        LOAD: begin
          if (bits_issued == BIW'(CHAIN_LENGTH)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (accept) begin
            data_nxt           = word_data[WORD_WIDTH-1];
            enable_nxt         = 1'b1;
            shreg_nxt          = word_data << 1;
            // A short final word only contributes its top bits_left bits.
            word_bits_left_nxt = (32'(bits_left) < WORD_WIDTH)
                                 ? WBW'(bits_left) - WBW'(1)
                                 : WBW'(WORD_WIDTH - 1);
            bits_issued_nxt    = bits_issued + BIW'(1);
            words_accepted_nxt = words_accepted + WAW'(1);
          end else if (word_bits_left != '0) begin
            data_nxt           = shreg[WORD_WIDTH-1];
            enable_nxt         = 1'b1;
            shreg_nxt          = shreg << 1;
            word_bits_left_nxt = word_bits_left - WBW'(1);
            bits_issued_nxt    = bits_issued + BIW'(1);
          end
          // Otherwise: stall, enable drops and the chain holds.
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      state           <= IDLE;
      bits_issued     <= '0;
      words_accepted  <= '0;
      word_bits_left  <= '0;
      shreg           <= '0;
      config_data_out <= 1'b0;
      config_enable   <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_nxt;
      bits_issued     <= bits_issued_nxt;
      words_accepted  <= words_accepted_nxt;
      word_bits_left  <= word_bits_left_nxt;
      shreg           <= shreg_nxt;
      config_data_out <= data_nxt;
      config_enable   <= enable_nxt;
      done            <= done_nxt;
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Testbench for config_chain_loader: one instance with CHAIN_LENGTH=24
// (whole words) and one with CHAIN_LENGTH=20 (partial last word).
module tb_config_chain_loader;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nrst;
  logic         start_s [2];
  logic         abort_s [2];
  logic         valid_s [2];
  logic [W-1:0] data_s  [2];
  logic         ready_s [2];
  logic         dout_s  [2];
  logic         en_s    [2];
  logic         busy_s  [2];
  logic         done_s  [2];

  int checks   = 0;
  int failures = 0;

  config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(24)) dut0 (
    .config_clock(clk), .config_nreset(nrst), .start(start_s[0]), .abort(abort_s[0]),
    .word_data(data_s[0]), .word_valid(valid_s[0]), .word_ready(ready_s[0]),
    .config_data_out(dout_s[0]), .config_enable(en_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(20)) dut1 (
    .config_clock(clk), .config_nreset(nrst), .start(start_s[1]), .abort(abort_s[1]),
    .word_data(data_s[1]), .word_valid(valid_s[1]), .word_ready(ready_s[1]),
    .config_data_out(dout_s[1]), .config_enable(en_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  function automatic int len_of(input int sel);
    return (sel == 0) ? 24 : 20;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one load on instance sel. pct: chance (percent) of offering a word
  // each cycle; drop_len: cycles of withheld valid while ready after word 0;
  // abort_at: bit count at which to abort (<0 none); restart_at: cycle at
  // which a stray start is pulsed mid-load (<0 none).
  task automatic run_load(input int sel, input int pct, input int drop_len,
                          input int abort_at, input int restart_at);
    int           L, nw, noff, widx, stall_exp, gaps, first_en, last_en, cyc, drop, bad, done_cyc;
    bit           ready_late, fin, v;
    logic [W-1:0] words [$];
    bit           cap   [$];
    logic [W-1:0] w;
    L = len_of(sel); nw = (L + W - 1) / W; noff = nw + 1;
    widx = 0; stall_exp = 0; gaps = 0; first_en = -1; last_en = -1; cyc = 0;
    drop = drop_len; ready_late = 0; fin = 0; done_cyc = -1;
    for (int i = 0; i < noff; i++) words.push_back(W'($urandom));

    @(negedge clk); start_s[sel] = 1'b1;
    @(negedge clk); start_s[sel] = 1'b0;
    check("busy_after_start", 32'(busy_s[sel]), 1);
    check("done_cleared_on_start", 32'(done_s[sel]), 0);

    while (cyc < 400 && !fin) begin
      if (done_s[sel]) begin
        fin = 1; done_cyc = cyc;
      end else if (en_s[sel]) begin
        cap.push_back(dout_s[sel]);
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end else if (first_en >= 0) begin
        gaps++;
      end
      if (!fin) begin
        if (abort_at >= 0 && cap.size() == abort_at) begin
          abort_s[sel] = 1'b1; valid_s[sel] = 1'b1; start_s[sel] = 1'b0;
          @(negedge clk);
          abort_s[sel] = 1'b0; valid_s[sel] = 1'b0;
          check("abort_enable", 32'(en_s[sel]), 0);
          check("abort_busy", 32'(busy_s[sel]), 0);
          check("abort_done", 32'(done_s[sel]), 0);
          return;
        end
        start_s[sel] = (cyc == restart_at);
        v = 0;
        if (widx < noff) v = ($urandom_range(99) < pct);
        if (drop > 0 && widx == 1 && ready_s[sel]) begin v = 0; drop--; end
        valid_s[sel] = v;
        data_s[sel]  = (widx < noff) ? words[widx] : '0;
        if (ready_s[sel] && widx >= nw) ready_late = 1;
        if (ready_s[sel] && !v && widx >= 1 && widx < nw) stall_exp++;
        if (v && ready_s[sel]) widx++;
        @(negedge clk); cyc++;
      end
    end
    valid_s[sel] = 1'b0; start_s[sel] = 1'b0;

    bad = 0;
    for (int i = 0; i < L && i < cap.size(); i++) begin
      w = words[i / W];
      if (cap[i] !== w[W - 1 - (i % W)]) bad++;
    end
    check("load_completed", 32'(fin), 1);
    check("enabled_bit_count", cap.size(), L);
    check("stream_bit_errors", bad, 0);
    check("words_consumed", widx, nw);
    check("ready_after_final_word", 32'(ready_late), 0);
    check("done_latency", done_cyc, last_en + 1);
    check("stall_cycles", gaps, stall_exp);
    check("busy_after_done", 32'(busy_s[sel]), 0);
    // done is a level; IDLE ignores offered words.
    valid_s[sel] = 1'b1;
    check("ready_in_idle", 32'(ready_s[sel]), 0);
    @(negedge clk);
    valid_s[sel] = 1'b0;
    check("done_holds", 32'(done_s[sel]), 1);
    check("idle_enable", 32'(en_s[sel]), 0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      start_s[s] = 1'b0; abort_s[s] = 1'b0; valid_s[s] = 1'b0; data_s[s] = '0;
    end
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_data", 32'(dout_s[s]), 0);
      check("reset_enable", 32'(en_s[s]), 0);
      check("reset_busy", 32'(busy_s[s]), 0);
      check("reset_done", 32'(done_s[s]), 0);
      check("reset_ready", 32'(ready_s[s]), 0);
    end

    // Continuous stream, whole words.
    run_load(0, 100, 0, -1, -1);
    // Partial final word, extra word offered but not consumed.
    run_load(1, 100, 0, -1, -1);
    // Three stall cycles after the first word.
    run_load(0, 100, 3, -1, -1);
    // Abort after 10 bits, then a full reload.
    run_load(0, 100, 0, 10, -1);
    run_load(0, 100, 0, -1, -1);
    // Stray start during LOAD.
    run_load(0, 100, 0, -1, 5);
    run_load(1, 70, 0, -1, 3);

    // start together with abort in IDLE stays IDLE.
    @(negedge clk); start_s[0] = 1'b1; abort_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0; abort_s[0] = 1'b0;
    check("start_abort_idle_busy", 32'(busy_s[0]), 0);
    @(negedge clk);
    check("start_abort_idle_ready", 32'(ready_s[0]), 0);

    // Randomised loads with random valid gaps.
    for (int k = 0; k < 8; k++) run_load(k % 2, $urandom_range(100, 30), 0, -1, -1);

    // Asynchronous reset mid-load.
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0; valid_s[0] = 1'b1; data_s[0] = 8'hFF;
    repeat (4) @(negedge clk);
    check("pre_reset_enable", 32'(en_s[0]), 1);
    check("pre_reset_data", 32'(dout_s[0]), 1);
    nrst = 1'b0;
    #1;
    check("async_reset_data", 32'(dout_s[0]), 0);
    check("async_reset_enable", 32'(en_s[0]), 0);
    check("async_reset_busy", 32'(busy_s[0]), 0);
    check("async_reset_done", 32'(done_s[0]), 0);
    check("async_reset_ready", 32'(ready_s[0]), 0);
    @(negedge clk); nrst = 1'b1; valid_s[0] = 1'b0;
    @(negedge clk);
    check("post_reset_busy", 32'(busy_s[0]), 0);
    check("post_reset_done", 32'(done_s[0]), 0);
    check("post_reset_enable", 32'(en_s[0]), 0);
    run_load(0, 100, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
